// File: rtl/sc_pkg.sv
// Shared constants, width helpers and state encoding for the stochastic-computing decoder path.
package sc_pkg;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_NCH    = 4;
  localparam int DEF_W      = 32;
  localparam int DEF_FRAMES = 8;
  localparam int DEF_SHIFT  = 1;

  localparam int BEAT_W = clog2(DEF_NCH * DEF_W + 1);
  localparam int ACC_W  = clog2(DEF_NCH * DEF_W * DEF_FRAMES + 1);
  localparam int OUT_W  = ACC_W + DEF_SHIFT;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/sc_popcount.sv
// Combinational ones counter for one W-bit stochastic channel word.
module sc_popcount
  import sc_pkg::*;
#(
  parameter  int W     = DEF_W,
  localparam int CNT_W = clog2(W + 1)
) (
  input  logic [W-1:0]     bits,
  output logic [CNT_W-1:0] count
);

  // NOTE: blocking '=' inside always_comb; the running sum is a combinational chain, not state.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: popcounts FRAMES beats of NCH channel words and emits the scaled total.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter  int NCH    = DEF_NCH,
  parameter  int W      = DEF_W,
  parameter  int FRAMES = DEF_FRAMES,
  parameter  int SHIFT  = DEF_SHIFT,
  localparam int OUT_W  = clog2(NCH * W * FRAMES + 1) + SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy
);

  localparam int PC_W   = clog2(W + 1);
  localparam int BEAT_W = clog2(NCH * W + 1);
  localparam int ACC_W  = clog2(NCH * W * FRAMES + 1);
  localparam int CNT_W  = (FRAMES > 1) ? clog2(FRAMES) : 1;

  logic [PC_W-1:0]   ch_count [NCH];
  logic [BEAT_W-1:0] beat_sum;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  beat_cnt;
  logic              last_slot;
  logic              fire;
  state_t            state;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sc_popcount #(.W(W)) u_popcount (
      .bits  (in_data[c*W +: W]),
      .count (ch_count[c])
    );
  end

  always_comb begin
    beat_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      beat_sum = beat_sum + BEAT_W'(ch_count[c]);
    end
    acc_sum   = acc + ACC_W'(beat_sum);
    last_slot = (beat_cnt == CNT_W'(FRAMES - 1));
    // Only the closing beat has to wait for a stuck result; earlier beats never touch the output register.
    in_ready  = !clear && !(last_slot && out_valid && !out_ready);
    fire      = in_valid && in_ready;
  end

  assign busy = (state == ST_ACC);

  // NOTE: non-blocking '<=' for every register so all state updates see the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      beat_cnt  <= '0;
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (clear) begin
        acc      <= '0;
        beat_cnt <= '0;
        state    <= ST_IDLE;
      end else if (fire) begin
        if (last_slot) begin
          acc      <= '0;
          beat_cnt <= '0;
          state    <= ST_IDLE;
        end else begin
          acc      <= acc_sum;
          beat_cnt <= beat_cnt + CNT_W'(1);
          state    <= ST_ACC;
        end
      end

      // A new result may replace the one being consumed on the same edge, giving bubble-free output.
      if (fire && last_slot) begin
        out_valid <= 1'b1;
        out_data  <= OUT_W'(acc_sum) << SHIFT;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Scoreboard bench for sc_stream_decoder at NCH=4, W=32, FRAMES=8, SHIFT=1.
module tb_sc_stream_decoder;

  localparam int NCH    = 4;
  localparam int W      = 32;
  localparam int FRAMES = 8;
  localparam int SHIFT  = 1;
  localparam int OUT_W  = 12;
  localparam int DW     = NCH * W;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  logic [OUT_W-1:0] exp_q [$];

  sc_stream_decoder #(.NCH(NCH), .W(W), .FRAMES(FRAMES), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every handshake on the output pops one expected result.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      vcount++;
      if (out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%0d required=none", out_data);
        end else begin
          check("sb_out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // Present one beat and hold it until accepted; final beats queue their expected result.
  task automatic send(input logic [DW-1:0] d, input bit is_final, input logic [OUT_W-1:0] exp,
                      input bit no_stall);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    if (no_stall) check("no_stall", t, 0);
    if (is_final) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic conv(input logic [DW-1:0] d, input logic [OUT_W-1:0] exp);
    for (int i = 0; i < FRAMES; i++) send(d, i == FRAMES - 1, exp, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] all1;
    logic [DW-1:0] one_bit;
    logic [DW-1:0] ch0_full;
    logic [DW-1:0] per_ch;
    all1      = '1;
    ch0_full  = '0;
    ch0_full[W-1:0] = '1;
    per_ch    = '0;
    for (int c = 0; c < NCH; c++) per_ch[c*W + c + 3] = 1'b1;

    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rst = 1'b1;
    idle(1);

    // All ones with one-cycle latency check, then all zeros.
    for (int i = 0; i < FRAMES - 1; i++) send(all1, 1'b0, '0, 1'b1);
    check("busy_mid", busy, 1);
    check("valid_before_final", out_valid, 0);
    send(all1, 1'b1, 12'd2048, 1'b1);
    check("valid_after_final", out_valid, 1);
    check("busy_after_final", busy, 0);
    idle(2);
    conv('0, 12'd0);
    idle(2);

    // Single set bit: ch0 bit29, then walk across every position.
    one_bit = '0; one_bit[29] = 1'b1;
    conv(one_bit, 12'd16);
    for (int p = 0; p < DW; p++) begin
      one_bit = '0; one_bit[p] = 1'b1;
      conv(one_bit, 12'd16);
    end
    idle(2);

    // Backpressure: pending result stalls only the final beat of the next conversion.
    out_ready = 1'b0;
    conv(all1, 12'd2048);
    for (int i = 0; i < FRAMES - 1; i++) send(ch0_full, 1'b0, '0, 1'b1);
    in_valid = 1'b1; in_data = ch0_full;
    @(negedge clk);
    check("bp_final_stalled", in_ready, 0);
    check("bp_pending_valid", out_valid, 1);
    @(negedge clk);
    check("bp_still_stalled", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", in_ready, 1);
    exp_q.push_back(12'd512);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    idle(2);

    // Clear after three beats; the beat presented during clear is dropped.
    for (int i = 0; i < 3; i++) send(all1, 1'b0, '0, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_data = all1;
    @(negedge clk);
    check("clear_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clear_busy", busy, 0);
    conv(per_ch, 12'd64);
    idle(2);

    // Async reset mid-conversion.
    for (int i = 0; i < 5; i++) send(all1, 1'b0, '0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_mid_busy", busy, 0);
    check("arst_mid_valid", out_valid, 0);
    check("arst_mid_data", out_data, 0);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    conv(all1, 12'd2048);
    idle(2);

    // Async reset with a result pending.
    out_ready = 1'b0;
    conv(all1, 12'd2048);
    @(negedge clk);
    check("arst_pend_valid_before", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_pend_valid", out_valid, 0);
    check("arst_pend_data", out_data, 0);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
    conv(all1, 12'd2048);
    idle(3);

    // Back-to-back conversions with no stall.
    vcount = 0;
    for (int i = 0; i < 2 * FRAMES; i++)
      send(all1, (i % FRAMES) == FRAMES - 1, 12'd2048, 1'b1);
    idle(4);
    check("b2b_valid_cycles", vcount, 2);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
